// File: rtl/as_qspi_target_pkg.sv
// Shared constants and state encoding for the QSPI target.
package as_qspi_target_pkg;

    localparam logic [7:0] qspi_cmd_write = 8'h38;
    localparam logic [7:0] qspi_cmd_read  = 8'h6B;
    localparam int         qspi_dummy     = 2;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR,
        WDATA,
        DUMMY,
        RDATA,
        IGNORE
    } e_qspi_tstate;

endpackage

// File: rtl/as_edge_sync.sv
// Multi-flop synchroniser with a rise/fall detector on the synchronised level.
module as_edge_sync #(
    parameter int STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic rise_o,
    output logic fall_o
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;
    logic              prev_q;
    logic              prev_d;

    for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
        if (gi == 0) begin : g_first
            assign sync_d[gi] = d_i;
        end else begin : g_rest
            assign sync_d[gi] = sync_q[gi-1];
        end
    end

    always_comb prev_d = sync_q[STAGES-1];

    // Chain resets low: a CS held low across reset then never produces a
    // falling edge, so the interrupted frame is ignored until CS cycles.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign rise_o = sync_q[STAGES-1] & ~prev_q;
    assign fall_o = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/as_qspi_target.sv
// QSPI responder: oversampled serial frames mapped to 64-bit memory reads and writes.
module as_qspi_target
    import as_qspi_target_pkg::*;
#(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 64,
    parameter int DUMMY       = qspi_dummy,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              sck_i,
    input  logic              cs_n_i,
    input  logic [3:0]        io_i,
    output logic [3:0]        io_o,
    output logic              io_oe_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    output logic              mem_we_o,
    output logic              mem_re_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    input  logic              mem_rvalid_i,
    output logic              err_o
);

    localparam int                CNT_W      = 8;
    localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CMD_LAST   = CNT_W'(1);
    localparam logic [CNT_W-1:0]  ADDR_LAST  = CNT_W'(ADDR_W / 4 - 1);
    localparam logic [CNT_W-1:0]  DATA_LAST  = CNT_W'(DATA_W / 4 - 1);
    localparam logic [CNT_W-1:0]  DUMMY_LAST = CNT_W'(DUMMY - 1);
    localparam logic [ADDR_W-1:0] WORD_STEP  = ADDR_W'(8);

    logic sck_rise, sck_fall, cs_rise, cs_fall;
    logic [3:0] io_sync_q [SYNC_STAGES];
    logic [3:0] io_sync_d [SYNC_STAGES];
    logic [3:0] io_nib;

    as_edge_sync #(.STAGES(SYNC_STAGES)) u_sck_sync (
        .clk_i (clk_i), .rst_i (rst_i), .d_i (sck_i),
        .rise_o(sck_rise), .fall_o(sck_fall)
    );

    as_edge_sync #(.STAGES(SYNC_STAGES)) u_cs_sync (
        .clk_i (clk_i), .rst_i (rst_i), .d_i (cs_n_i),
        .rise_o(cs_rise), .fall_o(cs_fall)
    );

    for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_io_sync
        if (gi == 0) begin : g_first
            assign io_sync_d[gi] = io_i;
        end else begin : g_rest
            assign io_sync_d[gi] = io_sync_q[gi-1];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) io_sync_q <= '{default: '0};
        else       io_sync_q <= io_sync_d;
    end

    assign io_nib = io_sync_q[SYNC_STAGES-1];

    e_qspi_tstate      state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              we_q, we_d, re_q, re_d;
    logic [3:0]        io_q, io_d;
    logic              oe_q, oe_d, err_q, err_d;
    logic              is_read_q, is_read_d;
    logic              rd_pend_q, rd_pend_d, rd_valid_q, rd_valid_d, rd_bad_q, rd_bad_d;
    logic              nib_bad;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        shift_d    = shift_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        we_d       = 1'b0;
        re_d       = 1'b0;
        io_d       = io_q;
        oe_d       = oe_q;
        err_d      = err_q;
        is_read_d  = is_read_q;
        rd_pend_d  = rd_pend_q;
        rd_valid_d = rd_valid_q;
        rd_bad_d   = rd_bad_q;
        nib_bad    = (cnt_q == '0) ? ~rd_valid_q : rd_bad_q;

        // Write address advances the cycle after the strobe so the strobe sees the old one.
        if (we_q) addr_d = addr_q + WORD_STEP;

        case (state_q)
            IDLE: begin
                if (cs_fall) begin
                    state_d = CMD;
                    cnt_d   = '0;
                    shift_d = '0;
                    err_d   = 1'b0;
                end
            end
            CMD, ADDR, WDATA: begin
                if (sck_rise) begin
                    shift_d = {shift_q[DATA_W-5:0], io_nib};
                    cnt_d   = cnt_q + CNT_ONE;
                    if (state_q == CMD && cnt_q == CMD_LAST) begin
                        cnt_d     = '0;
                        is_read_d = (shift_d[7:0] == qspi_cmd_read);
                        if (shift_d[7:0] == qspi_cmd_write || shift_d[7:0] == qspi_cmd_read) begin
                            state_d = ADDR;
                        end else begin
                            state_d = IGNORE;
                            err_d   = 1'b1;
                        end
                    end else if (state_q == ADDR && cnt_q == ADDR_LAST) begin
                        cnt_d  = '0;
                        addr_d = {shift_d[ADDR_W-1:3], 3'b000};
                        if (is_read_q) begin
                            state_d    = (DUMMY == 0) ? RDATA : as_qspi_target_pkg::DUMMY;
                            re_d       = 1'b1;
                            rd_pend_d  = 1'b1;
                            rd_valid_d = 1'b0;
                        end else begin
                            state_d = WDATA;
                        end
                    end else if (state_q == WDATA && cnt_q == DATA_LAST) begin
                        cnt_d   = '0;
                        wdata_d = shift_d;
                        we_d    = 1'b1;
                    end
                end
            end
            as_qspi_target_pkg::DUMMY: begin
                if (sck_rise) begin
                    cnt_d = cnt_q + CNT_ONE;
                    if (cnt_q == DUMMY_LAST) begin
                        cnt_d   = '0;
                        state_d = RDATA;
                    end
                end
            end
            RDATA: begin
                if (sck_fall) begin
                    oe_d    = 1'b1;
                    shift_d = {shift_q[DATA_W-5:0], 4'h0};
                    io_d    = nib_bad ? 4'hF : shift_q[DATA_W-1 -: 4];
                    if (cnt_q == '0) begin
                        rd_bad_d   = nib_bad;
                        rd_valid_d = 1'b0;
                        if (nib_bad) begin
                            err_d     = 1'b1;
                            rd_pend_d = 1'b0;
                        end
                    end
                    if (cnt_q == DATA_LAST) begin
                        cnt_d     = '0;
                        addr_d    = addr_q + WORD_STEP;
                        re_d      = 1'b1;
                        rd_pend_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
            end
            IGNORE:  oe_d = 1'b0;
            default: state_d = IDLE;
        endcase

        if (rd_pend_q && rd_pend_d && mem_rvalid_i) begin
            shift_d    = mem_rdata_i;
            rd_valid_d = 1'b1;
            rd_pend_d  = 1'b0;
        end

        if (cs_rise) begin
            state_d    = IDLE;
            oe_d       = 1'b0;
            rd_pend_d  = 1'b0;
            rd_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            shift_q    <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            we_q       <= 1'b0;
            re_q       <= 1'b0;
            io_q       <= '0;
            oe_q       <= 1'b0;
            err_q      <= 1'b0;
            is_read_q  <= 1'b0;
            rd_pend_q  <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_bad_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            shift_q    <= shift_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            we_q       <= we_d;
            re_q       <= re_d;
            io_q       <= io_d;
            oe_q       <= oe_d;
            err_q      <= err_d;
            is_read_q  <= is_read_d;
            rd_pend_q  <= rd_pend_d;
            rd_valid_q <= rd_valid_d;
            rd_bad_q   <= rd_bad_d;
        end
    end

    assign io_o        = io_q;
    assign io_oe_o     = oe_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;
    assign mem_we_o    = we_q;
    assign mem_re_o    = re_q;
    assign err_o       = err_q;

endmodule

// File: tb/tb_as_qspi_target.sv
// Frame-level bench for the QSPI target: vector table plus reset/abort sequences.
module tb_as_qspi_target;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        sck_i = 1'b0;
    logic        cs_n_i = 1'b1;
    logic [3:0]  io_i = 4'h0;
    logic [3:0]  io_o;
    logic        io_oe_o;
    logic [15:0] mem_addr_o;
    logic [63:0] mem_wdata_o;
    logic        mem_we_o;
    logic        mem_re_o;
    logic [63:0] mem_rdata_i = '0;
    logic        mem_rvalid_i = 1'b0;
    logic        err_o;

    as_qspi_target dut (
        .clk_i(clk), .rst_i(rst_i), .sck_i(sck_i), .cs_n_i(cs_n_i),
        .io_i(io_i), .io_o(io_o), .io_oe_o(io_oe_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .mem_we_o(mem_we_o), .mem_re_o(mem_re_o),
        .mem_rdata_i(mem_rdata_i), .mem_rvalid_i(mem_rvalid_i), .err_o(err_o)
    );

    initial forever #5 clk = ~clk;

    typedef struct {
        logic [7:0]  cmd;
        logic [15:0] addr;
        logic [63:0] data;
        int          nwords;
        bit          withhold;
        bit          exp_err;
    } vec_t;

    typedef struct {
        logic [15:0] addr;
        logic [63:0] data;
    } wr_t;

    wr_t        wr_q[$];
    logic [3:0] rd_q[$];
    int         n_cmp = 0;
    int         n_bad = 0;
    int         we_cnt = 0;
    int         re_cnt = 0;
    bit         withhold = 1'b0;
    bit         rv_pend = 1'b0;
    logic [63:0] rv_data = '0;

    function automatic void check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endfunction

    function automatic logic [63:0] rd_model(input logic [15:0] a);
        return (a == 16'h0008) ? 64'hDEADBEEFCAFEF00D : {4{a ^ 16'h5A5A}};
    endfunction

    // Memory model and write scoreboard; read data returns one cycle after the request.
    always @(negedge clk) begin
        wr_t w;
        mem_rvalid_i = rv_pend;
        mem_rdata_i  = rv_data;
        rv_pend      = mem_re_o && !withhold;
        if (mem_re_o) begin
            re_cnt++;
            rv_data = rd_model(mem_addr_o);
        end
        if (mem_re_o || mem_we_o) check("re_we_exclusive", 64'(mem_re_o & mem_we_o), 64'd0);
        if (mem_we_o) begin
            we_cnt++;
            if (wr_q.size() == 0) begin
                check("unexpected_we", 64'd1, 64'd0);
            end else begin
                w = wr_q.pop_front();
                check("we_addr", 64'(mem_addr_o), 64'(w.addr));
                check("we_data", mem_wdata_o, w.data);
            end
        end
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic sck_cycle(input logic [3:0] nib);
        io_i = nib;
        wait_clk(4);
        sck_i = 1'b1;
        wait_clk(4);
        sck_i = 1'b0;
    endtask

    task automatic read_cycle();
        logic [3:0] exp;
        wait_clk(4);
        if (rd_q.size() == 0) begin
            check("rd_queue_underrun", 64'd1, 64'd0);
        end else begin
            exp = rd_q.pop_front();
            check("rd_nibble", 64'(io_o), 64'(exp));
        end
        check("rd_oe", 64'(io_oe_o), 64'd1);
        sck_i = 1'b1;
        wait_clk(4);
        sck_i = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_io"},    64'(io_o),       64'd0);
        check({tag, "_oe"},    64'(io_oe_o),    64'd0);
        check({tag, "_we"},    64'(mem_we_o),   64'd0);
        check({tag, "_re"},    64'(mem_re_o),   64'd0);
        check({tag, "_addr"},  64'(mem_addr_o), 64'd0);
        check({tag, "_wdata"}, mem_wdata_o,     64'd0);
        check({tag, "_err"},   64'(err_o),      64'd0);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int          we0, re0;
        logic [15:0] a;
        logic [63:0] d;
        we0 = we_cnt;
        re0 = re_cnt;
        a = {v.addr[15:3], 3'b000};
        withhold = v.withhold;
        cs_n_i = 1'b0;
        wait_clk(4);
        check("err_clear_on_cs", 64'(err_o), 64'd0);
        sck_cycle(v.cmd[7:4]);
        sck_cycle(v.cmd[3:0]);
        for (int i = 0; i < 4; i++) sck_cycle(v.addr[15-4*i -: 4]);
        if (v.cmd == 8'h38) begin
            for (int w = 0; w < v.nwords; w++) begin
                d = v.data + 64'(w) * 64'h0101010101010101;
                wr_q.push_back('{addr: a + 16'(8 * w), data: d});
                for (int i = 0; i < 16; i++) sck_cycle(d[63-4*i -: 4]);
            end
        end else if (v.cmd == 8'h6B) begin
            sck_cycle(4'h0);
            check("oe_low_in_dummy", 64'(io_oe_o), 64'd0);
            sck_cycle(4'h0);
            d = rd_model(a);
            for (int i = 0; i < 16; i++) rd_q.push_back(v.withhold ? 4'hF : d[63-4*i -: 4]);
            for (int i = 0; i < 16; i++) read_cycle();
        end else begin
            for (int i = 0; i < 4; i++) sck_cycle(4'h5);
            check("oe_low_ignore", 64'(io_oe_o), 64'd0);
        end
        wait_clk(4);
        cs_n_i = 1'b1;
        wait_clk(6);
        check("oe_low_after_cs", 64'(io_oe_o), 64'd0);
        check("err_end", 64'(err_o), 64'(v.exp_err));
        check("we_count", 64'(we_cnt - we0), (v.cmd == 8'h38) ? 64'(v.nwords) : 64'd0);
        check("re_count", 64'(re_cnt - re0), (v.cmd == 8'h6B) ? 64'd2 : 64'd0);
        check("wr_queue_drained", 64'(wr_q.size()), 64'd0);
        withhold = 1'b0;
        $display("frame %0d: cmd=%h addr=%h words=%0d withhold=%0d err=%0d", idx, v.cmd, v.addr,
                 v.nwords, v.withhold, err_o);
    endtask

    vec_t vecs[7];

    initial begin
        int we0, re0;
        vecs[0] = '{8'h38, 16'h0010, 64'h0123456789ABCDEF, 1, 1'b0, 1'b0};
        vecs[1] = '{8'h6B, 16'h0008, 64'h0,                1, 1'b0, 1'b0};
        vecs[2] = '{8'h38, 16'hFFF8, 64'h1122334455667788, 2, 1'b0, 1'b0};
        vecs[3] = '{8'h6B, 16'h0020, 64'h0,                1, 1'b1, 1'b1};
        vecs[4] = '{8'hA5, 16'h1234, 64'h0,                1, 1'b0, 1'b1};
        vecs[5] = '{8'h38, 16'h0013, 64'hA5A5C3C30F0F9669, 1, 1'b0, 1'b0};
        vecs[6] = '{8'h6B, 16'h0045, 64'h0,                1, 1'b0, 1'b0};

        wait_clk(5);
        check_reset_outputs("por");
        rst_i = 1'b0;
        wait_clk(6);

        for (int k = 0; k < 7; k++) run_vec(vecs[k], k);

        // CS dropped after 7 write-data nibbles: partial word must vanish.
        we0 = we_cnt;
        cs_n_i = 1'b0;
        wait_clk(4);
        sck_cycle(4'h3); sck_cycle(4'h8);
        for (int i = 0; i < 4; i++) sck_cycle(4'h1);
        for (int i = 0; i < 7; i++) sck_cycle(4'(i + 1));
        wait_clk(4);
        cs_n_i = 1'b1;
        wait_clk(6);
        check("abort_we_count", 64'(we_cnt - we0), 64'd0);
        check("abort_oe", 64'(io_oe_o), 64'd0);
        $display("frame abort: write cut after 7 nibbles");
        run_vec(vecs[0], 7);

        // Reset in the middle of a read with CS still low.
        cs_n_i = 1'b0;
        wait_clk(4);
        sck_cycle(4'h6); sck_cycle(4'hB);
        sck_cycle(4'h0); sck_cycle(4'h0); sck_cycle(4'h0); sck_cycle(4'h8);
        sck_cycle(4'h0); sck_cycle(4'h0);
        rd_q.push_back(4'hD); rd_q.push_back(4'hE); rd_q.push_back(4'hA); rd_q.push_back(4'hD);
        for (int i = 0; i < 4; i++) read_cycle();
        rst_i = 1'b1;
        wait_clk(1);
        check_reset_outputs("midrst");
        rst_i = 1'b0;
        we0 = we_cnt;
        re0 = re_cnt;
        for (int i = 0; i < 6; i++) begin
            sck_cycle(4'h0);
            check("post_rst_oe", 64'(io_oe_o), 64'd0);
        end
        check("post_rst_we", 64'(we_cnt - we0), 64'd0);
        check("post_rst_re", 64'(re_cnt - re0), 64'd0);
        wait_clk(4);
        cs_n_i = 1'b1;
        wait_clk(6);
        $display("frame reset: read interrupted by rst_i");
        run_vec(vecs[2], 8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
